// File: rtl/raw_pkg.sv
// raw_pkg: shared types for the RAW hazard scoreboard.
// Optional feature macro: RAW_FORWARDING_EN (see raw_scoreboard.sv).
package raw_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             is_load;
  } raw_entry_t;

  function automatic int idx_width(int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/raw_scoreboard_if.sv
// raw_scoreboard_if: decode-side bundle of the RAW hazard unit.
// Master = decode/testbench side, slave = scoreboard side.
interface raw_scoreboard_if
  import raw_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NSRC  = 2,
  parameter int DEPTH = 3
);

  logic                  id_valid;
  logic                  flush;
  logic [NSRC*REG_W-1:0] id_rs_sel;
  logic [NSRC-1:0]       id_rs_used;
  logic [REG_W-1:0]      id_rd_sel;
  logic                  id_wr_en;
  logic                  id_is_load;
  logic [DEPTH*XLEN-1:0] stg_val;
  logic [NSRC*XLEN-1:0]  rgf_rs_val;
  logic [NSRC*XLEN-1:0]  raw_rs_val;
  logic                  stall;
  logic [31:0]           stall_cnt;

  modport master (
    output id_valid, flush, id_rs_sel,
    output id_rs_used, id_rd_sel,
    output id_wr_en, id_is_load,
    output stg_val, rgf_rs_val,
    input  raw_rs_val, stall, stall_cnt
  );

  modport slave (
    input  id_valid, flush, id_rs_sel,
    input  id_rs_used, id_rd_sel,
    input  id_wr_en, id_is_load,
    input  stg_val, rgf_rs_val,
    output raw_rs_val, stall, stall_cnt
  );

endinterface

// File: rtl/raw_fwd_select.sv
// raw_fwd_select: youngest-match search over the scoreboard
// for one source register; reports hit, readiness and stage.
module raw_fwd_select
  import raw_pkg::*;
#(
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 1,
  parameter int IDX_W      = idx_width(DEPTH)
) (
  input  raw_entry_t [DEPTH-1:0] ent_i,
  input  logic [REG_W-1:0]       rs_i,
  output logic                   hit_o,
  output logic                   ready_o,
  output logic [IDX_W-1:0]       idx_o
);

  // Scan oldest to youngest so the lowest index wins.
  always_comb begin
    hit_o   = 1'b0;
    ready_o = 1'b0;
    idx_o   = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (ent_i[k].valid && ent_i[k].rd == rs_i) begin
        hit_o   = 1'b1;
        idx_o   = IDX_W'(k);
        ready_o = !ent_i[k].is_load ||
                  (k >= LOAD_STAGE);
      end
    end
  end

endmodule

// File: rtl/raw_scoreboard.sv
// raw_scoreboard: RAW hazard unit between decode and execute.
// Macro RAW_FORWARDING_EN enables stage forwarding (else stall).
module raw_scoreboard
  import raw_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int NSRC       = 2,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 1
) (
  input logic           clk,
  input logic           rst,
  raw_scoreboard_if.slave bus
);

  localparam int IDX_W = idx_width(DEPTH);

  raw_entry_t [DEPTH-1:0]       sb_q, sb_d;
  logic [31:0]                  cnt_q, cnt_d;
  logic [NSRC-1:0]              hit, ready, haz;
  logic [NSRC-1:0][IDX_W-1:0]   idx;
  logic [NSRC*XLEN-1:0]         opnd;
  logic                         stall;
  logic                         issue;

  for (genvar s = 0; s < NSRC; s++) begin : g_src
    raw_fwd_select #(
      .DEPTH      (DEPTH),
      .LOAD_STAGE (LOAD_STAGE),
      .IDX_W      (IDX_W)
    ) u_sel (
      .ent_i   (sb_q),
      .rs_i    (bus.id_rs_sel[s*REG_W +: REG_W]),
      .hit_o   (hit[s]),
      .ready_o (ready[s]),
      .idx_o   (idx[s])
    );
  end

  // Resolve each operand: x0, regfile, forwarded, or hazard.
  always_comb begin
    opnd = '0;
    haz  = '0;
    for (int s = 0; s < NSRC; s++) begin
      if (bus.id_rs_sel[s*REG_W +: REG_W] == REG_X0) begin
        opnd[s*XLEN +: XLEN] = '0;
      end else if (!bus.id_rs_used[s]) begin
        opnd[s*XLEN +: XLEN] = bus.rgf_rs_val[s*XLEN +: XLEN];
      end else begin
`ifdef RAW_FORWARDING_EN
        if (hit[s] && ready[s]) begin
          opnd[s*XLEN +: XLEN] =
            bus.stg_val[int'(idx[s])*XLEN +: XLEN];
        end else begin
          opnd[s*XLEN +: XLEN] = bus.rgf_rs_val[s*XLEN +: XLEN];
          haz[s] = hit[s];
        end
`else
        opnd[s*XLEN +: XLEN] = bus.rgf_rs_val[s*XLEN +: XLEN];
        haz[s] = hit[s];
`endif
      end
    end
  end

`ifndef RAW_FORWARDING_EN
  logic unused_nofwd;
  assign unused_nofwd = ^{bus.stg_val, ready, idx};
`endif

  assign stall = bus.id_valid && !bus.flush && (|haz);
  assign issue = bus.id_valid && bus.id_wr_en && !stall &&
                 !bus.flush && (bus.id_rd_sel != REG_X0);

  // Next scoreboard: shift toward WB, new entry or bubble at EX.
  always_comb begin
    sb_d = '0;
    for (int k = 1; k < DEPTH; k++) begin
      sb_d[k] = sb_q[k-1];
    end
    if (issue) begin
      sb_d[0] = raw_entry_t'{
        valid:   1'b1,
        rd:      bus.id_rd_sel,
        is_load: bus.id_is_load
      };
    end
    cnt_d = cnt_q + {31'd0, stall};
  end

  // Scoreboard and stall counter state; reset drops all tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_q  <= '0;
      cnt_q <= '0;
    end else begin
      sb_q  <= sb_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.raw_rs_val = opnd;
  assign bus.stall      = stall;
  assign bus.stall_cnt  = cnt_q;

endmodule

// File: tb/tb_raw_scoreboard.sv
// tb_raw_scoreboard: directed and random checks of raw_scoreboard
// against an age-based in-flight list model.
module tb_raw_scoreboard;
  import raw_pkg::*;

  localparam int XLEN       = 32;
  localparam int NSRC       = 2;
  localparam int DEPTH      = 3;
  localparam int LOAD_STAGE = 1;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  raw_scoreboard_if #(
    .XLEN(XLEN), .NSRC(NSRC), .DEPTH(DEPTH)
  ) bus ();

  raw_scoreboard #(
    .XLEN(XLEN), .NSRC(NSRC),
    .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int rd;
    bit ld;
    int age;
  } rec_t;

  rec_t q[$];
  int   m_cnt;
  bit   m_stall;
  int   n_cmp;
  int   n_bad;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] stg(int k);
    return bus.stg_val[k*XLEN +: XLEN];
  endfunction

  function automatic logic [31:0] rgf(int s);
    return bus.rgf_rs_val[s*XLEN +: XLEN];
  endfunction

  function automatic logic [31:0] opv(int s);
    return bus.raw_rs_val[s*XLEN +: XLEN];
  endfunction

  task automatic drive(bit v, bit fl, int rs0, int rs1,
                       bit [1:0] used, int rd, bit wr,
                       bit ld);
    bus.id_valid   = v;
    bus.flush      = fl;
    bus.id_rs_sel  = {5'(rs1), 5'(rs0)};
    bus.id_rs_used = used;
    bus.id_rd_sel  = 5'(rd);
    bus.id_wr_en   = wr;
    bus.id_is_load = ld;
    bus.stg_val    = {$urandom, $urandom, $urandom};
    bus.rgf_rs_val = {$urandom, $urandom};
  endtask

  task automatic look(string tag);
    bit haz_any;
    haz_any = 0;
    #1;
    for (int s = 0; s < NSRC; s++) begin
      int rs;
      int best;
      bit hz;
      bit cmp_op;
      logic [31:0] exp;
      rs     = int'(bus.id_rs_sel[s*REG_W +: REG_W]);
      hz     = 0;
      cmp_op = 1;
      exp    = rgf(s);
      if (rs == 0) begin
        exp = 0;
      end else if (bus.id_rs_used[s]) begin
        best = -1;
        foreach (q[i]) begin
          if (q[i].rd == rs &&
              (best < 0 || q[i].age < q[best].age))
            best = i;
        end
        if (best >= 0) begin
`ifdef RAW_FORWARDING_EN
          if (!q[best].ld || q[best].age >= LOAD_STAGE) begin
            exp = stg(q[best].age);
          end else begin
            hz     = 1;
            cmp_op = 0;
          end
`else
          hz = 1;
`endif
        end
      end
      haz_any |= hz;
      if (cmp_op)
        chk($sformatf("%s op%0d", tag, s), opv(s), exp);
    end
    m_stall = bus.id_valid && !bus.flush && haz_any;
    chk({tag, " stall"}, {31'd0, bus.stall},
        {31'd0, m_stall});
    chk({tag, " cnt"}, bus.stall_cnt, m_cnt);
  endtask

  task automatic tick(string tag);
    bit   issue;
    rec_t r;
    issue = bus.id_valid && bus.id_wr_en && !m_stall &&
            !bus.flush && bus.id_rd_sel != 0 && !rst;
    r.rd  = int'(bus.id_rd_sel);
    r.ld  = bus.id_is_load;
    r.age = 0;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_cnt = 0;
    end else begin
      foreach (q[i]) q[i].age++;
      for (int i = q.size() - 1; i >= 0; i--)
        if (q[i].age >= DEPTH) q.delete(i);
      if (issue) q.push_front(r);
      if (m_stall) m_cnt++;
    end
    #1;
    chk({tag, " cnt_post"}, bus.stall_cnt, m_cnt);
  endtask

  task automatic step(string tag);
    look(tag);
    tick(tag);
  endtask

  task automatic do_reset(string tag);
    rst = 1'b1;
    q.delete();
    m_cnt = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    look(tag);
    tick(tag);
    rst = 1'b0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      step("idle");
    end
  endtask

  initial begin
    int n;
    n_cmp = 0;
    n_bad = 0;
    m_cnt = 0;
    rst   = 1'b1;

    // reset with a live decode reading x5
    drive(1, 0, 5, 0, 2'b01, 0, 0, 0);
    bus.rgf_rs_val[31:0] = 32'h11;
    look("reset");
    chk("reset op0", opv(0), 32'h11);
    chk("reset stall", {31'd0, bus.stall}, 32'd0);
    chk("reset cnt", bus.stall_cnt, 32'd0);
    tick("reset");
    tick("reset");
    rst = 1'b0;

    // ALU-use at distance 1
    drive(1, 0, 0, 0, 2'b00, 5, 1, 0);
    step("add_x5");
    drive(1, 0, 5, 0, 2'b01, 0, 0, 0);
    bus.stg_val[31:0] = 32'h2A;
    look("alu_use");
`ifdef RAW_FORWARDING_EN
    chk("alu_use op0", opv(0), 32'h2A);
    chk("alu_use stall", {31'd0, bus.stall}, 32'd0);
    tick("alu_use");
`else
    n = 0;
    while (bus.stall && n < 10) begin
      tick("alu_use");
      n++;
      drive(1, 0, 5, 0, 2'b01, 0, 0, 0);
      look("alu_use");
    end
    chk("alu_use stalls", n, DEPTH);
    chk("alu_use op0", opv(0), rgf(0));
    tick("alu_use");
`endif
    idle(4);

    // load-use, counter starts from reset
    do_reset("lu_rst");
    drive(1, 0, 0, 0, 2'b00, 7, 1, 1);
    step("lw_x7");
    drive(1, 0, 0, 7, 2'b10, 0, 0, 0);
    look("load_use");
    n = 0;
    while (bus.stall && n < 10) begin
      tick("load_use");
      n++;
      drive(1, 0, 0, 7, 2'b10, 0, 0, 0);
      look("load_use");
    end
`ifdef RAW_FORWARDING_EN
    chk("load_use stalls", n, 1);
    bus.stg_val[XLEN +: XLEN] = 32'hDEAD;
    look("load_use_fwd");
    chk("load_use op1", opv(1), 32'hDEAD);
`else
    chk("load_use stalls", n, DEPTH);
    chk("load_use op1", opv(1), rgf(1));
`endif
    chk("load_use cnt", bus.stall_cnt, n);
    tick("load_use");
    idle(4);

    // youngest match wins
    drive(1, 0, 0, 0, 2'b00, 3, 1, 0);
    step("iss_x3a");
    drive(1, 0, 0, 0, 2'b00, 9, 1, 0);
    step("iss_x9");
    drive(1, 0, 0, 0, 2'b00, 3, 1, 0);
    step("iss_x3b");
    drive(1, 0, 3, 0, 2'b01, 0, 0, 0);
    bus.stg_val = {32'hC, 32'hB, 32'hA};
    look("youngest");
`ifdef RAW_FORWARDING_EN
    chk("youngest op0", opv(0), 32'hA);
`else
    chk("youngest stall", {31'd0, bus.stall}, 32'd1);
`endif
    tick("youngest");
    idle(4);

    // x0 destination and x0 source
    drive(1, 0, 0, 0, 2'b00, 0, 1, 0);
    step("addi_x0");
    drive(1, 0, 0, 0, 2'b01, 0, 0, 0);
    look("x0_read");
    chk("x0 op0", opv(0), 32'd0);
    chk("x0 stall", {31'd0, bus.stall}, 32'd0);
    tick("x0_read");

    // unused source matching an unready load
    drive(1, 0, 0, 0, 2'b00, 4, 1, 1);
    step("lw_x4");
    drive(1, 0, 0, 4, 2'b01, 0, 0, 0);
    look("unused");
    chk("unused stall", {31'd0, bus.stall}, 32'd0);
    chk("unused op1", opv(1), rgf(1));
    tick("unused");
    idle(4);

    // flush masks stall and kills the decode write
    drive(1, 0, 0, 0, 2'b00, 6, 1, 1);
    step("lw_x6");
    drive(1, 1, 6, 0, 2'b01, 8, 1, 0);
    look("flush");
    chk("flush stall", {31'd0, bus.stall}, 32'd0);
    tick("flush");
    drive(1, 0, 8, 0, 2'b01, 0, 0, 0);
    look("flush_after");
    chk("flush_after stall", {31'd0, bus.stall}, 32'd0);
    chk("flush_after op0", opv(0), rgf(0));
    tick("flush_after");
    idle(4);

    // random traffic with occasional mid-stream reset
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1;
        q.delete();
        m_cnt = 0;
        drive(1, 0, $urandom_range(0, 7),
              $urandom_range(0, 7), 2'b11, 0, 0, 0);
        look("rand_rst");
        tick("rand_rst");
        rst = 1'b0;
      end else begin
        drive($urandom_range(0, 7) != 0,
              $urandom_range(0, 7) == 0,
              $urandom_range(0, 7),
              $urandom_range(0, 7),
              2'($urandom_range(0, 3)),
              $urandom_range(0, 7),
              1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
        step("rand");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
